ram_arbiter: RTL



---
 rtl/ram_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter serialising two requesters onto the single-port data RAM.
// Define ARB_FIXED_PRIO_EN to make port 0 win every tie instead.
module ram_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic                     req0_wen,
    input  logic [ADDRESS_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0]    req0_wdata,
    output logic                     rsp0_valid,
    output logic [DATA_WIDTH-1:0]    rsp0_rdata,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic                     req1_wen,
    input  logic [ADDRESS_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0]    req1_wdata,
    output logic                     rsp1_valid,
    output logic [DATA_WIDTH-1:0]    rsp1_rdata,
    output logic                     ram_wEn,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic                     take;
    logic                     pick;
    logic                     grant_q;
    logic                     lat_wen;
    logic [ADDRESS_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0]    lat_wdata;
`ifndef ARB_FIXED_PRIO_EN
    logic                     last_grant;
`endif

    // pick = 1 selects port 1
    always_comb begin
        pick = req1_valid;
        if (req0_valid && req1_valid) begin
`ifdef ARB_FIXED_PRIO_EN
            pick = 1'b0;
`else
            pick = ~last_grant;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    take    = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req0_ready = take && !pick && !reset;
    assign req1_ready = take && pick && !reset;
    assign rsp0_valid = (state_q == RESP) && !grant_q;
    assign rsp1_valid = (state_q == RESP) && grant_q;
    assign ram_wEn    = (state_q == ACCESS) && lat_wen;
    assign ram_addr   = lat_addr;
    assign ram_dataIn = lat_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            lat_wen    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            if (take) begin
                grant_q   <= pick;
                lat_wen   <= pick ? req1_wen : req0_wen;
                lat_addr  <= pick ? req1_addr : req0_addr;
                lat_wdata <= pick ? req1_wdata : req0_wdata;
`ifndef ARB_FIXED_PRIO_EN
                last_grant <= pick;
`endif
            end
            // RAM drove dataOut at the mid-cycle negedge of ACCESS
            if (state_q == ACCESS) begin
                if (grant_q)
                    rsp1_rdata <= lat_wen ? '0 : ram_dataOut;
                else
                    rsp0_rdata <= lat_wen ? '0 : ram_dataOut;
            end
        end
    end

endmodule
